// File: rtl/hex_display_scanner_pkg.sv
// ----------------------------------------------------------------------------
// hex_display_scanner_pkg
// Shared constants for the 8-digit hex display scanner.
//   CLK_DIV_DEFAULT : clk cycles spent on each digit slot
//   AN_OFF/SEG_OFF  : all-dark anode and segment patterns (active-low)
//   SEG_TABLE       : 16 seven-segment codes, entry n in bits [7n+6:7n],
//                     active-low, bit order {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
package hex_display_scanner_pkg;

   localparam int CLK_DIV_DEFAULT = 50000;

   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Listed from F down to 0 so that glyph 0 sits in the least significant slot.
   localparam logic [16*7-1:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex_display_scanner_if.sv
// ----------------------------------------------------------------------------
// hex_display_scanner_if
// Bundles the value/strobe inputs and the display drive outputs.
//   hex_in      : 32-bit value to display
//   load        : one-cycle capture strobe for hex_in
//   halt        : halt indication (sticky inside the scanner)
//   blank_lz_en : leading-zero blanking enable
//   an          : digit enables, active-low
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low
//   frame_done  : one-cycle pulse after each frame boundary
// master = the side that supplies values, slave = the scanner.
// ----------------------------------------------------------------------------
interface hex_display_scanner_if;

   logic [31:0] hex_in;
   logic        load;
   logic        halt;
   logic        blank_lz_en;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   modport master (
      output hex_in, load, halt, blank_lz_en,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  hex_in, load, halt, blank_lz_en,
      output an, seg, dp, frame_done
   );

endinterface

// File: rtl/hex_display_scanner_hex_to_seg7.sv
// ----------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex digit to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-low segments {g,f,e,d,c,b,a}
// ----------------------------------------------------------------------------
module hex_to_seg7
   import hex_display_scanner_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[7*nibble +: 7];

endmodule

// File: rtl/hex_display_scanner.sv
// ----------------------------------------------------------------------------
// hex_display_scanner
// Time-multiplexes a 32-bit value onto eight active-low seven-segment digits.
// A new value is held in a pending register and only committed at a frame
// boundary so a frame never shows a mix of old and new digits.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : hex_display_scanner_if.slave (value inputs, display outputs)
// ----------------------------------------------------------------------------
module hex_display_scanner
   import hex_display_scanner_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
)
(
   input  logic                  clk,
   input  logic                  reset,
   hex_display_scanner_if.slave  bus
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_reg;
   logic [2:0]       idx_reg;
   logic [2:0]       idx_next;
   logic [31:0]      display_reg;
   logic [31:0]      display_next;
   logic [31:0]      pending_reg;
   logic             pending;
   logic             halt_latched;
   logic             halt_next;
   logic [7:0]       an_reg;
   logic [6:0]       seg_reg;
   logic             dp_reg;
   logic             frame_done_reg;

   logic             tick;
   logic             boundary;
   logic [7:0]       upper_zero;
   logic             blank_digit;
   logic [3:0]       nibble;
   logic [6:0]       seg_raw;

   assign tick      = (count_reg == CNT_LAST);
   assign boundary  = tick && (idx_reg == 3'd7);
   assign idx_next  = idx_reg + 3'd1;
   assign halt_next = halt_latched | bus.halt;

   // Value shown in the coming frame; a load on the boundary itself bypasses
   // the pending register.
   always_comb begin
      display_next = display_reg;
      if (boundary) begin
         if (bus.load) begin
            display_next = bus.hex_in;
         end else if (pending) begin
            display_next = pending_reg;
         end
      end
   end

   // upper_zero[gi]: nibbles 7..gi of the coming value are all zero.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lz
         assign upper_zero[gi] = ~|(display_next >> (4 * gi));
      end
   endgenerate

   assign blank_digit = bus.blank_lz_en && (idx_next != 3'd0) && upper_zero[idx_next];
   assign nibble      = display_next[4*idx_next +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (seg_raw)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg      <= '0;
         idx_reg        <= 3'd0;
         display_reg    <= 32'd0;
         pending_reg    <= 32'd0;
         pending        <= 1'b0;
         halt_latched   <= 1'b0;
         an_reg         <= AN_OFF;
         seg_reg        <= SEG_OFF;
         dp_reg         <= 1'b1;
         frame_done_reg <= 1'b0;
      end else begin
         count_reg      <= tick ? '0 : count_reg + 1'b1;
         halt_latched   <= halt_next;
         display_reg    <= display_next;
         frame_done_reg <= boundary;

         if (boundary) begin
            pending <= 1'b0;
         end else if (bus.load) begin
            pending_reg <= bus.hex_in;
            pending     <= 1'b1;
         end

         if (tick) begin
            idx_reg <= idx_next;
            if (blank_digit) begin
               an_reg  <= AN_OFF;
               seg_reg <= SEG_OFF;
               dp_reg  <= 1'b1;
            end else begin
               an_reg  <= ~(8'b1 << idx_next);
               seg_reg <= seg_raw;
               dp_reg  <= ~halt_next;
            end
         end
      end
   end

   assign bus.an         = an_reg;
   assign bus.seg        = seg_reg;
   assign bus.dp         = dp_reg;
   assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// ----------------------------------------------------------------------------
// tb_hex_display_scanner
// Scoreboard bench for hex_display_scanner with CLK_DIV=4. A reference model
// predicts each digit update on the tick edge and queues it; the monitor pops
// and compares on the following falling edge. Directed checks use the digit
// values actually captured from the DUT.
// ----------------------------------------------------------------------------
module tb_hex_display_scanner;

   localparam int CLK_DIV = 4;

   typedef struct {
      int         d;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   logic clk;
   logic reset;

   hex_display_scanner_if ifc ();

   hex_display_scanner #(.CLK_DIV(CLK_DIV)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   // ---------------- reference model ----------------
   disp_t       q[$];
   int          m_cnt, m_idx;
   logic [31:0] m_disp, m_pv;
   logic        m_pend, m_hl, m_fd;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = 0; m_idx = 0; m_disp = 0; m_pv = 0;
         m_pend = 0; m_hl = 0; m_fd = 0;
         q.delete();
      end else begin
         bit    tk, bnd;
         int    msd;
         disp_t e;
         tk  = (m_cnt == CLK_DIV - 1);
         bnd = tk && (m_idx == 7);
         if (ifc.halt) m_hl = 1;
         if (bnd) begin
            if (ifc.load) begin
               m_disp = ifc.hex_in; m_pend = 0;
            end else if (m_pend) begin
               m_disp = m_pv; m_pend = 0;
            end
         end else if (ifc.load) begin
            m_pv = ifc.hex_in; m_pend = 1;
         end
         m_fd = bnd;
         if (tk) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 8;
            msd = 0;
            for (int k = 0; k < 8; k++)
               if (((m_disp >> (4 * k)) & 32'hF) != 0) msd = k;
            e.d = m_idx;
            if (ifc.blank_lz_en && m_idx > msd) begin
               e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
               e.an  = 8'hFF ^ (8'h01 << m_idx);
               e.seg = glyph(4'((m_disp >> (4 * m_idx)) & 32'hF));
               e.dp  = ~m_hl;
            end
            q.push_back(e);
         end else begin
            m_cnt++;
         end
      end
   end

   // ---------------- monitor ----------------
   disp_t      cur;
   logic [7:0] sh_an  [8];
   logic [6:0] sh_seg [8];
   logic       sh_dp  [8];
   logic       saw08;
   logic       seen_first;
   logic [7:0] first_an;

   always @(negedge clk) begin
      if (reset) begin
         cur.d = 0; cur.an = 8'hFF; cur.seg = 7'h7F; cur.dp = 1'b1;
         seen_first = 1'b0;
         check("reset_out", {16'd0, ifc.an, ifc.seg, ifc.dp, ifc.frame_done},
               {16'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
      end else begin
         if (q.size() > 0) begin
            cur = q.pop_front();
            check($sformatf("digit%0d", cur.d), {16'd0, ifc.an, ifc.seg, ifc.dp},
                  {16'd0, cur.an, cur.seg, cur.dp});
            $display("digit %0d: an=%h seg=%h dp=%b (want an=%h seg=%h dp=%b)",
                     cur.d, ifc.an, ifc.seg, ifc.dp, cur.an, cur.seg, cur.dp);
            sh_an[cur.d]  = ifc.an;
            sh_seg[cur.d] = ifc.seg;
            sh_dp[cur.d]  = ifc.dp;
            if (ifc.seg == 7'h08) saw08 = 1'b1;
         end else begin
            check("hold", {16'd0, ifc.an, ifc.seg, ifc.dp}, {16'd0, cur.an, cur.seg, cur.dp});
         end
         if (!seen_first && ifc.an != 8'hFF) begin
            seen_first = 1'b1;
            first_an   = ifc.an;
         end
         check("frame_done", {31'd0, ifc.frame_done}, {31'd0, m_fd});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_frames(input int n);
      for (int k = 0; k < n; k++) begin
         int c = 0;
         do begin
            @(negedge clk);
            c++;
         end while (!ifc.frame_done && c < 200);
         if (!ifc.frame_done) check("frame_timeout", 32'd0, 32'd1);
      end
      #1;
   endtask

   task automatic do_load(input logic [31:0] v);
      @(negedge clk);
      ifc.hex_in = v;
      ifc.load   = 1'b1;
      @(negedge clk);
      ifc.load   = 1'b0;
   endtask

   task automatic load_on_boundary(input logic [31:0] v);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!(m_cnt == CLK_DIV - 1 && m_idx == 7) && c < 200);
      if (c >= 200) check("boundary_timeout", 32'd0, 32'd1);
      ifc.hex_in = v;
      ifc.load   = 1'b1;
      @(negedge clk);
      ifc.load   = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      ifc.hex_in = 32'd0; ifc.load = 1'b0; ifc.halt = 1'b0; ifc.blank_lz_en = 1'b0;
      saw08 = 1'b0; seen_first = 1'b0; first_an = 8'hFF;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // First tick after reset lights digit 1.
      wait_frames(1);
      check("first_digit_an", {24'd0, first_an}, {24'd0, 8'hFD});

      // Mid-frame load takes effect only at the next boundary.
      repeat (6) @(negedge clk);
      do_load(32'h12345678);
      wait_frames(2);
      check("d0_an",  {24'd0, sh_an[0]},  {24'd0, 8'hFE});
      check("d0_seg", {25'd0, sh_seg[0]}, {25'd0, 7'h00});
      check("d7_an",  {24'd0, sh_an[7]},  {24'd0, 8'h7F});
      check("d7_seg", {25'd0, sh_seg[7]}, {25'd0, 7'h79});

      // Back-to-back loads: last one wins.
      repeat (6) @(negedge clk);
      saw08 = 1'b0;
      do_load(32'hAAAAAAAA);
      do_load(32'h55555555);
      wait_frames(2);
      for (int i = 0; i < 8; i++)
         check($sformatf("b2b_seg%0d", i), {25'd0, sh_seg[i]}, {25'd0, 7'h12});
      check("never_08", {31'd0, saw08}, 32'd0);

      // Leading-zero blanking.
      ifc.blank_lz_en = 1'b1;
      repeat (6) @(negedge clk);
      do_load(32'h000000A0);
      wait_frames(2);
      for (int i = 2; i < 8; i++)
         check($sformatf("lz_an%0d", i), {24'd0, sh_an[i]}, {24'd0, 8'hFF});
      check("lz_d1_seg", {25'd0, sh_seg[1]}, {25'd0, 7'h08});
      check("lz_d0_seg", {25'd0, sh_seg[0]}, {25'd0, 7'h40});
      repeat (6) @(negedge clk);
      do_load(32'h00000000);
      wait_frames(2);
      for (int i = 1; i < 8; i++)
         check($sformatf("zero_an%0d", i), {24'd0, sh_an[i]}, {24'd0, 8'hFF});
      check("zero_d0_an", {24'd0, sh_an[0]}, {24'd0, 8'hFE});

      // Load on the boundary cycle goes straight to the display.
      ifc.blank_lz_en = 1'b0;
      load_on_boundary(32'h0000000F);
      #1;
      check("bnd_d0_seg", {25'd0, sh_seg[0]}, {25'd0, 7'h0E});
      wait_frames(2);
      check("bnd_d0_seg_next", {25'd0, sh_seg[0]}, {25'd0, 7'h0E});
      check("bnd_d1_seg", {25'd0, sh_seg[1]}, {25'd0, 7'h40});

      // One-cycle halt pulse is sticky.
      repeat (5) @(negedge clk);
      ifc.halt = 1'b1;
      @(negedge clk);
      ifc.halt = 1'b0;
      wait_frames(2);
      for (int i = 0; i < 8; i++)
         check($sformatf("halt_dp%0d", i), {31'd0, sh_dp[i]}, 32'd0);
      wait_frames(1);
      check("halt_dp_later", {31'd0, sh_dp[4]}, 32'd0);

      // Reset mid-frame discards the pending load.
      repeat (5) @(negedge clk);
      do_load(32'hDEADBEEF);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_reset", {16'd0, ifc.an, ifc.seg, ifc.dp}, {16'd0, 8'hFF, 7'h7F, 1'b1});
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_frames(2);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("post_rst_seg%0d", i), {25'd0, sh_seg[i]}, {25'd0, 7'h40});
         check($sformatf("post_rst_dp%0d", i), {31'd0, sh_dp[i]}, 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter CLK_DIV, default 50000, meaning clk cycles per digit slot (legal range >= 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hex_in  input  32  value to display; the syscall a0 display value.
REQ-005 load  input  1  one-cycle strobe; capture hex_in (the syscall Enable).
REQ-006 halt  input  1  halt indication from the syscall decoder (Halt).
REQ-007 blank_lz_en  input  1  enables leading-zero blanking.
REQ-008 an  output  8  digit enables, active-low; an[i] drives nibble i (bit 0 = hex_in[3:0]).
REQ-009 seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  decimal point, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 and wrap; tick is asserted in the cycle the count equals CLK_DIV-1.
REQ-013 Digit index idx (3 bits) SHALL advance by 1 on each tick, with wrap 7->0.
REQ-014 The frame boundary SHALL be a tick while idx==7.
REQ-015 load SHALL copy hex_in into pending_reg and set pending; back-to-back loads: last wins.
REQ-016 At a frame boundary with pending set, display_reg SHALL take pending_reg and pending SHALL clear; display_reg never changes at any other time (no tearing).
REQ-017 load coincident with a frame boundary SHALL write hex_in directly into display_reg and leave pending clear.
REQ-018 an/seg/dp SHALL be registered and update only on the edge that samples tick, showing digit idx_next from the post-update display_reg (1-cycle latency from tick).
REQ-019 Exactly one an bit SHALL be low for an unblanked digit; a blanked digit drives an=8'hFF, seg=7'h7F.
REQ-020 With blank_lz_en=1, digit i>0 SHALL be blanked when nibbles 7..i of display_reg are all zero; digit 0 is never blanked.
REQ-021 Segment map: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
REQ-022 A halt high for any cycle SHALL set sticky halt_latched; while set, dp=0 on every unblanked digit, else dp=1.
REQ-023 frame_done SHALL be high exactly the one cycle following the frame-boundary edge.
REQ-024 blank_lz_en SHALL be sampled at each tick; no other input is timing-sensitive.

Reset
REQ-025 On reset: an=8'hFF, seg=7'h7F, dp=1, frame_done=0, idx=0, prescaler=0, display_reg=0, pending_reg=0, pending=0, halt_latched=0.
REQ-026 Reset asserted mid-frame SHALL force those values immediately and discard any pending load.
REQ-027 After reset release, outputs SHALL stay dark until the first tick, which shows digit 1 (idx_next).

Structure
REQ-028 The segment table constants and the CLK_DIV default SHALL live in the shared package.
REQ-029 One combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out), SHALL implement REQ-021.

Verification (CLK_DIV=4)
REQ-030 Load 32'h12345678 mid-frame, blank off -> current frame unchanged. After the boundary: digit0 an=8'hFE seg=7'h00; digit7 an=8'h7F seg=7'h79.
REQ-031 Load 32'hAAAAAAAA then 32'h55555555 before the boundary -> next frame all digits seg=7'h12; 7'h08 never shown.
REQ-032 blank_lz_en=1 and display 32'h000000A0 -> digits 2..7 an=8'hFF; digit1 seg=7'h08; digit0 seg=7'h40. Display 0 -> only digit0 lit.
REQ-033 load pulse on the boundary cycle with 32'hF -> digit0 shows seg=7'h0E in that frame; pending stays 0.
REQ-034 One-cycle halt pulse -> dp=0 on all lit digits for every later frame until reset.
REQ-035 Reset mid-frame with pending set -> an=8'hFF, seg=7'h7F at once; after release the display shows 0 and the pending value never appears.
